powlib_mfifo_arb: RTL and testbench

Single-clock, N-channel buffered stream merger. Each of N valid/ready input channels feeds its own depth-D FIFO. A round-robin arbiter drains the FIFOs into one registered output stream tagged with the source channel index. It sits downstream of the powlib_afifo crossings and multiplexes several same-clock streams onto one consumer, such as a UART or DMA path.

---
 rtl/powlib_mfifo_arb.sv | 183 ++++++++++++++++++
 tb/tb_powlib_mfifo_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/powlib_mfifo_arb.sv
// powlib_mfifo_arb: N-channel buffered stream merger.
// Every input channel has its own depth-D FIFO. A round-robin arbiter drains
// those FIFOs into one registered output beat, tagged with the source channel.
// Optional packet lock: define POWLIB_MFIFO_ARB_LOCK_EN to keep the grant on a
// channel until that channel's beat with last=1 has been popped.
//
// state  | meaning
// IDLE   | output register empty
// STREAM | output register holds a beat, grants rotate per beat
// LOCK   | output register holds a beat of a packet that is still open (lock build only)
module powlib_mfifo_arb #(
  parameter int    W  = 32,
  parameter int    D  = 16,
  parameter int    N  = 3,
  parameter string ID = "MFIFO_ARB",
  localparam int   CW = (N > 1) ? $clog2(N) : 1,
  localparam int   AW = $clog2(D)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] wrdata,
  input  logic [N-1:0]   wrvld,
  input  logic [N-1:0]   wrlast,
  output logic [N-1:0]   wrrdy,
  output logic [W-1:0]   rddata,
  output logic [CW-1:0]  rdch,
  output logic           rdlast,
  output logic           rdvld,
  input  logic           rdrdy
);

`ifdef POWLIB_MFIFO_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, STREAM, LOCK} state_t;
`else
  typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

  logic [W:0]    mem_q [N][D];
  logic [AW:0]   cnt_q [N];
  logic [AW:0]   cnt_d [N];
  logic [AW-1:0] wptr_q [N];
  logic [AW-1:0] wptr_d [N];
  logic [AW-1:0] rptr_q [N];
  logic [AW-1:0] rptr_d [N];
  logic [N-1:0]  wr_dly_q, wr_dly_d;
  logic [CW-1:0] gptr_q, gptr_d;
  state_t        state_q, state_d;
  logic [W-1:0]  rddata_q, rddata_d;
  logic [CW-1:0] rdch_q, rdch_d;
  logic          rdlast_q, rdlast_d;
`ifdef POWLIB_MFIFO_ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic [CW-1:0] lock_ch_q, lock_ch_d;
`endif

  logic [N-1:0]  push, pop, avail;
  logic          load, sel_vld;
  logic [CW-1:0] sel;
  logic [W:0]    sel_word;
  int            idx;

  // Per-channel handshake and eligibility. A beat only becomes eligible one
  // cycle after it lands, which gives the two-edge push-to-output latency.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      wrrdy[c] = (cnt_q[c] != (AW+1)'(D));
      push[c]  = wrvld[c] && wrrdy[c];
      avail[c] = (cnt_q[c] > {{AW{1'b0}}, wr_dly_q[c]});
    end
  end

  // Round-robin search starting after the last granted channel.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(gptr_q) + k) % N;
`ifdef POWLIB_MFIFO_ARB_LOCK_EN
      if (!sel_vld && avail[idx] && (!lock_q || (lock_ch_q == CW'(idx)))) begin
`else
      if (!sel_vld && avail[idx]) begin
`endif
        sel_vld = 1'b1;
        sel     = CW'(idx);
      end
    end
    sel_word = mem_q[sel][rptr_q[sel]];
  end

  // FIFO pointer and count updates.
  always_comb begin
    load     = (state_q == IDLE) || rdrdy;
    wr_dly_d = push;
    for (int c = 0; c < N; c++) begin
      pop[c]    = load && sel_vld && (sel == CW'(c));
      wptr_d[c] = wptr_q[c] + AW'(push[c]);
      rptr_d[c] = rptr_q[c] + AW'(pop[c]);
      cnt_d[c]  = cnt_q[c];
      if (push[c] && !pop[c]) cnt_d[c] = cnt_q[c] + 1'b1;
      if (pop[c] && !push[c]) cnt_d[c] = cnt_q[c] - 1'b1;
    end
  end

  // Arbiter FSM and output register next-state.
  always_comb begin
    state_d  = state_q;
    gptr_d   = gptr_q;
    rddata_d = rddata_q;
    rdch_d   = rdch_q;
    rdlast_d = rdlast_q;
`ifdef POWLIB_MFIFO_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
`endif
    if (load) begin
      if (sel_vld) begin
        rddata_d = sel_word[W-1:0];
        rdlast_d = sel_word[W];
        rdch_d   = sel;
        gptr_d   = sel;
        state_d  = STREAM;
`ifdef POWLIB_MFIFO_ARB_LOCK_EN
        lock_d    = !sel_word[W];
        lock_ch_d = sel;
        if (!sel_word[W]) state_d = LOCK;
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Payload storage; contents are don't-care until counted, so no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= {wrlast[c], wrdata[c*W +: W]};
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        cnt_q[c]  <= '0;
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
      wr_dly_q <= '0;
      gptr_q   <= CW'(N-1);
      state_q  <= IDLE;
      rddata_q <= '0;
      rdch_q   <= '0;
      rdlast_q <= 1'b0;
`ifdef POWLIB_MFIFO_ARB_LOCK_EN
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else begin
      for (int c = 0; c < N; c++) begin
        cnt_q[c]  <= cnt_d[c];
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
      wr_dly_q <= wr_dly_d;
      gptr_q   <= gptr_d;
      state_q  <= state_d;
      rddata_q <= rddata_d;
      rdch_q   <= rdch_d;
      rdlast_q <= rdlast_d;
`ifdef POWLIB_MFIFO_ARB_LOCK_EN
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end

  assign rddata = rddata_q;
  assign rdch   = rdch_q;
  assign rdlast = rdlast_q;
  assign rdvld  = (state_q != IDLE);

endmodule

// File: tb/tb_powlib_mfifo_arb.sv
// Directed bench for powlib_mfifo_arb (W=32, D=16, N=3).
module tb_powlib_mfifo_arb;
  localparam int W = 32;
  localparam int D = 16;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N*W-1:0] wrdata = '0;
  logic [N-1:0] wrvld = '0;
  logic [N-1:0] wrlast = '0;
  logic [N-1:0] wrrdy;
  logic [W-1:0] rddata;
  logic [1:0]   rdch;
  logic         rdlast;
  logic         rdvld;
  logic         rdrdy = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  powlib_mfifo_arb #(.W(W), .D(D), .N(N)) dut (
    .clk(clk), .rst(rst), .wrdata(wrdata), .wrvld(wrvld), .wrlast(wrlast),
    .wrrdy(wrrdy), .rddata(rddata), .rdch(rdch), .rdlast(rdlast),
    .rdvld(rdvld), .rdrdy(rdrdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wrvld = '0;
    tick();
    chk("rst_wrrdy", wrrdy, 3'b111);
    chk("rst_rdvld", rdvld, 0);
    rst = 1'b1;
  endtask

  logic [32:0] sbq [N][$];
  logic [32:0] exp_w;
  logic [1:0]  lk_seq [4];
  logic [1:0]  lk_exp [4];
  int          nb;
  logic        hold;
  logic [31:0] hold_data;
  logic [1:0]  hold_ch;
  int          seqn;

  initial begin
    // Reset state and first-beat latency
    tick();
    tick();
    chk("reset_wrrdy", wrrdy, 3'b111);
    chk("reset_rdvld", rdvld, 0);
    chk("reset_rddata", rddata, 0);
    chk("reset_rdch", rdch, 0);
    chk("reset_rdlast", rdlast, 0);
    rst = 1'b1;
    rdrdy = 1'b1;
    wrdata[1*W +: W] = 32'hA5A5_A5A5;
    wrvld = 3'b010;
    tick();
    wrvld = '0;
    chk("lat_t0_rdvld", rdvld, 0);
    chk("lat_wrrdy", wrrdy, 3'b111);
    tick();
    chk("lat_t1_rdvld", rdvld, 0);
    tick();
    chk("lat_t2_rdvld", rdvld, 1);
    chk("lat_rddata", rddata, 32'hA5A5_A5A5);
    chk("lat_rdch", rdch, 1);
    chk("lat_rdlast", rdlast, 0);
    tick();
    chk("lat_drain", rdvld, 0);

    // Fairness: three channels with four beats each
    do_reset();
    rdrdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < N; c++) wrdata[c*W +: W] = 32'hF000_0000 | (c << 8) | i;
      wrvld = 3'b111;
      tick();
    end
    wrvld = '0;
    rdrdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("fair_rdvld", rdvld, 1);
      chk("fair_rdch", rdch, i % 3);
      chk("fair_rddata", rddata, 32'hF000_0000 | ((i % 3) << 8) | (i / 3));
      tick();
    end
    chk("fair_empty", rdvld, 0);

    // Full and pointer wrap on ch0, output held by a ch1 beat
    rdrdy = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wrdata[1*W +: W] = 32'hB000_0000 + r;
      wrvld = 3'b010;
      tick();
      wrvld = '0;
      tick();
      tick();
      tick();
      chk("full_blk_vld", rdvld, 1);
      chk("full_blk_ch", rdch, 1);
      for (int i = 0; i < 16; i++) begin
        wrdata[0 +: W] = 32'h1000_0000 + r * 256 + i;
        wrvld = 3'b001;
        tick();
        chk("full_wrrdy", wrrdy[0], (i == 15) ? 1'b0 : 1'b1);
      end
      wrdata[0 +: W] = 32'hDEAD_0000;
      tick();
      wrvld = '0;
      chk("full_17_wrrdy", wrrdy[0], 0);
      chk("full_hold_data", rddata, 32'hB000_0000 + r);
      rdrdy = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
        chk("wrap_rdvld", rdvld, 1);
        chk("wrap_rdch", rdch, 0);
        chk("wrap_rddata", rddata, 32'h1000_0000 + r * 256 + i);
        tick();
      end
      chk("wrap_empty", rdvld, 0);
      chk("wrap_wrrdy", wrrdy[0], 1);
      rdrdy = 1'b0;
    end

    // Random back-pressure with per-channel scoreboard
    hold = 1'b0;
    seqn = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 300) begin
        wrvld = N'($urandom_range(0, 7));
        wrlast = N'($urandom_range(0, 7));
        for (int c = 0; c < N; c++) wrdata[c*W +: W] = {8'(c), 24'(seqn + c)};
        seqn = seqn + 4;
        rdrdy = 1'($urandom_range(0, 1));
      end else begin
        wrvld = '0;
        rdrdy = 1'b1;
      end
      if (hold) begin
        chk("bp_stable_data", rddata, hold_data);
        chk("bp_stable_ch", rdch, hold_ch);
      end
      if (rdvld && rdrdy) begin
        if (sbq[rdch].size() == 0) chk("bp_extra_beat", 1, 0);
        else begin
          exp_w = sbq[rdch].pop_front();
          chk("bp_beat", {rdlast, rddata}, exp_w);
        end
      end
      for (int c = 0; c < N; c++)
        if (wrvld[c] && wrrdy[c]) sbq[c].push_back({wrlast[c], wrdata[c*W +: W]});
      hold = rdvld && !rdrdy;
      hold_data = rddata;
      hold_ch = rdch;
      tick();
    end
    wrlast = '0;
    for (int c = 0; c < N; c++) chk("bp_lost", sbq[c].size(), 0);
    chk("bp_idle", rdvld, 0);

    // Packet lock vs per-beat rotation
    do_reset();
    rdrdy = 1'b1;
    wrdata[0 +: W] = 32'h0000_00C0;
    wrdata[1*W +: W] = 32'h0000_00C1;
    wrlast = 3'b010;
    wrvld = 3'b011;
    tick();
    wrdata[0 +: W] = 32'h0000_01C0;
    wrlast = 3'b000;
    wrvld = 3'b001;
    tick();
    wrdata[0 +: W] = 32'h0000_02C0;
    wrlast = 3'b001;
    tick();
    wrvld = '0;
    wrlast = '0;
    nb = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (rdvld && nb < 4) begin
        lk_seq[nb] = rdch;
        nb++;
      end
      tick();
    end
`ifdef POWLIB_MFIFO_ARB_LOCK_EN
    lk_exp[0] = 2'd0; lk_exp[1] = 2'd0; lk_exp[2] = 2'd0; lk_exp[3] = 2'd1;
`else
    lk_exp[0] = 2'd0; lk_exp[1] = 2'd1; lk_exp[2] = 2'd0; lk_exp[3] = 2'd0;
`endif
    chk("lock_nbeats", nb, 4);
    for (int i = 0; i < 4; i++) if (i < nb) chk("lock_rdch", lk_seq[i], lk_exp[i]);

    // Asynchronous reset with beats queued
    rdrdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wrdata[2*W +: W] = 32'h5500_0000 + i;
      wrvld = 3'b100;
      tick();
    end
    wrvld = '0;
    tick();
    chk("arst_pre_vld", rdvld, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_rdvld", rdvld, 0);
    chk("arst_wrrdy", wrrdy, 3'b111);
    chk("arst_rddata", rddata, 0);
    tick();
    rst = 1'b1;
    rdrdy = 1'b1;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (rdvld) nb++;
      tick();
    end
    chk("arst_no_stale", nb, 0);
    wrdata[0 +: W] = 32'h7777_0001;
    wrvld = 3'b001;
    tick();
    wrvld = '0;
    tick();
    chk("arst_new_t1", rdvld, 0);
    tick();
    chk("arst_new_vld", rdvld, 1);
    chk("arst_new_data", rddata, 32'h7777_0001);
    chk("arst_new_ch", rdch, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
